// File: rtl/freq_entry_to_k.sv
// freq_entry_to_k: packed-BCD frequency setpoint (Hz) to DDS tuning word K = floor(freq_hz / DIVISOR).
// Sequential engine: digit check, MSD-first BCD-to-binary accumulate, then restoring divide by a constant.
module freq_entry_to_k #(
    parameter int NDIG    = 6,
    parameter int FREQ_W  = 20,
    parameter int DIVISOR = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] digits_combined,
    output logic [23:0]       K,
    output logic              valid,
    output logic              err,
    output logic              busy
);
    localparam int K_W     = 24;
    localparam int CNT_MAX = (NDIG > FREQ_W) ? NDIG : FREQ_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [FREQ_W:0] REM_DIV = (FREQ_W + 1)'(DIVISOR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ACCUM,
        S_DIV
    } state_t;

    state_t              state_q;
    logic [4*NDIG-1:0]   digits_q;
    logic [FREQ_W-1:0]   acc_q;
    logic [FREQ_W:0]     rem_q;
    logic [FREQ_W-1:0]   quo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [K_W-1:0]      k_q;
    logic                valid_q;
    logic                err_q;
    logic                busy_q;

    logic                digit_bad;
    logic [3:0]          digit_sel;
    logic [FREQ_W-1:0]   acc_d;
    logic [FREQ_W:0]     rem_shift;
    logic [FREQ_W:0]     rem_d;
    logic [FREQ_W-1:0]   quo_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        digit_bad = 1'b0;
        digit_sel = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (digits_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
            if (cnt_q == CNT_W'(i)) digit_sel = digits_q[4*i +: 4];
        end

        // acc*10 + digit without a multiplier
        acc_d = (acc_q << 3) + (acc_q << 1) + FREQ_W'(digit_sel);

        // One restoring-division step: bring in the next dividend bit, subtract if it fits
        rem_shift = (rem_q << 1) | {{FREQ_W{1'b0}}, acc_q[FREQ_W-1]};
        if (rem_shift >= REM_DIV) begin
            rem_d = rem_shift - REM_DIV;
            quo_d = (quo_q << 1) | {{(FREQ_W-1){1'b0}}, 1'b1};
        end else begin
            rem_d = rem_shift;
            quo_d = quo_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        digits_q <= digits_combined;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (digit_bad) begin
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(NDIG - 1);
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(FREQ_W - 1);
                        rem_q   <= '0;
                        quo_q   <= '0;
                        state_q <= S_DIV;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    acc_q <= acc_q << 1;
                    if (cnt_q == '0) begin
                        k_q     <= K_W'(quo_d);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign K     = k_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_freq_entry_to_k.sv
// Self-checking bench for freq_entry_to_k: table-driven vectors, a result scoreboard,
// and hand-written sequences for back-to-back, mid-conversion start and mid-conversion reset.
module tb_freq_entry_to_k;
    localparam int LAT_OK  = 27;
    localparam int LAT_ERR = 1;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [23:0] digits;
        logic [23:0] k;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] digits_combined = '0;
    logic [23:0] K;
    logic        valid;
    logic        err;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    vec_t sb[$];
    vec_t mon_e;
    logic valid_prev = 1'b0;

    freq_entry_to_k dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .digits_combined (digits_combined),
        .K               (K),
        .valid           (valid),
        .err             (err),
        .busy            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: every valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (!valid) check("err_without_valid", 32'(err), 32'd0);
            if (valid) begin
                check("busy_during_valid", 32'(busy), 32'd0);
                check("valid_one_cycle", 32'(valid_prev), 32'd0);
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check($sformatf("K_%06h", mon_e.digits), 32'(K), 32'(mon_e.k));
                    check($sformatf("err_%06h", mon_e.digits), 32'(err), 32'(mon_e.err));
                end
            end
            valid_prev = valid;
        end
    end

    // Drive a one-cycle start; c_n is the cycle count right after the sampling edge
    task automatic issue(input logic [23:0] d, output int c_n);
        @(posedge clk); #1;
        start = 1'b1;
        digits_combined = d;
        @(posedge clk); #1;
        start = 1'b0;
        c_n = cyc;
    endtask

    task automatic wait_valid(input int c_n, output int lat, output int busy_n);
        busy_n = 0;
        lat = -1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = cyc - c_n;
                break;
            end
            if (busy) busy_n++;
        end
        check("valid_seen", 32'(valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int c_n, lat, busy_n, exp_lat;
        exp_lat = v.err ? LAT_ERR : LAT_OK;
        issue(v.digits, c_n);
        sb.push_back(v);
        wait_valid(c_n, lat, busy_n);
        check($sformatf("latency_%06h", v.digits), 32'(lat), 32'(exp_lat));
        check($sformatf("busy_cycles_%06h", v.digits), 32'(busy_n), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   c_n, c_n2, lat, busy_n, nv;
        logic [23:0] d;
        int   val, pw, dig;

        // Expected K is floor(decimal value / 6); error vectors keep the previous K
        tbl[0]  = '{24'h000000, 24'd0,      1'b0};
        tbl[1]  = '{24'h000006, 24'd1,      1'b0};
        tbl[2]  = '{24'h000005, 24'd0,      1'b0};
        tbl[3]  = '{24'h999999, 24'd166666, 1'b0};
        tbl[4]  = '{24'h100000, 24'd16666,  1'b0};
        tbl[5]  = '{24'h000099, 24'd16,     1'b0};
        tbl[6]  = '{24'h012345, 24'd2057,   1'b0};
        tbl[7]  = '{24'h00A000, 24'd2057,   1'b1};
        tbl[8]  = '{24'hF00000, 24'd2057,   1'b1};
        tbl[9]  = '{24'h00000B, 24'd2057,   1'b1};
        tbl[10] = '{24'h000600, 24'd100,    1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_K", 32'(K), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Back-to-back: start held high; the second capture happens in the first valid cycle
        @(posedge clk); #1;
        start = 1'b1;
        digits_combined = 24'h999999;
        sb.push_back('{24'h999999, 24'd166666, 1'b0});
        sb.push_back('{24'h000012, 24'd2, 1'b0});
        @(posedge clk); #1;
        c_n = cyc;
        digits_combined = 24'h000012;
        wait_valid(c_n, lat, busy_n);
        check("b2b_first_latency", 32'(lat), 32'(LAT_OK));
        @(posedge clk); #1;
        start = 1'b0;
        c_n2 = cyc;
        check("b2b_restart_busy", 32'(busy), 32'd1);
        wait_valid(c_n2, lat, busy_n);
        check("b2b_second_latency", 32'(lat), 32'(LAT_OK));

        // Start pulse and input change mid-conversion are ignored
        issue(24'h012345, c_n);
        sb.push_back('{24'h012345, 24'd2057, 1'b0});
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        digits_combined = 24'h000006;
        @(posedge clk); #1;
        start = 1'b0;
        digits_combined = 24'h000777;
        wait_valid(c_n, lat, busy_n);
        check("midconv_latency", 32'(lat), 32'(LAT_OK));

        // Reset mid-conversion: no valid pulse, K cleared, then a fresh conversion works
        issue(24'h012345, c_n);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_K", 32'(K), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);
        v = '{24'h000600, 24'd100, 1'b0};
        run_vec(v);

        // Random valid setpoints against a decimal reference
        for (int r = 0; r < 8; r++) begin
            d = '0;
            val = 0;
            pw = 1;
            for (int i = 0; i < 6; i++) begin
                dig = int'($urandom_range(0, 9));
                d[4*i +: 4] = 4'(dig);
                val += dig * pw;
                pw *= 10;
            end
            v = '{d, 24'(val / 6), 1'b0};
            run_vec(v);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
